// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge: one transfer in flight, round-robin read/write
// arbitration, and APB errors or ACCESS timeouts returned as SLVERR.
module axil_apb_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned CntW  = $clog2(TIMEOUT + 2);
    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    rd_prio_q, rd_prio_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              prot_q, prot_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]        strb_q, strb_d;
    logic [1:0]              resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic rd_elig, wr_elig, grant_rd, grant_wr;

    // A write needs address and data in the same cycle; priority only matters on a tie.
    assign rd_elig  = s_arvalid;
    assign wr_elig  = s_awvalid & s_wvalid;
    assign grant_rd = rd_elig & (~wr_elig | rd_prio_q);
    assign grant_wr = wr_elig & ~grant_rd;

    always_comb begin
        state_d   = state_q;
        rd_prio_d = rd_prio_q;
        write_d   = write_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_rvalid  = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    s_arready = 1'b1;
                    write_d   = 1'b0;
                    addr_d    = s_araddr;
                    prot_d    = s_arprot;
                    wdata_d   = '0;
                    strb_d    = '0;
                end else if (grant_wr) begin
                    s_awready = 1'b1;
                    s_wready  = 1'b1;
                    write_d   = 1'b1;
                    addr_d    = s_awaddr;
                    prot_d    = s_awprot;
                    wdata_d   = s_wdata;
                    strb_d    = s_wstrb;
                end
                if (grant_rd || grant_wr) begin
                    rd_prio_d = ~rd_prio_q;
                    cnt_d     = '0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                psel    = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // A pready on the final allowed cycle still completes normally.
                if (pready) begin
                    resp_d  = pslverr ? 2'b10 : 2'b00;
                    if (!write_q) rdata_d = prdata;
                    state_d = StResp;
                end else if (TimeoutEn && cnt_q == CntLast) begin
                    resp_d  = 2'b10;
                    if (!write_q) rdata_d = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                s_bvalid = write_q;
                s_rvalid = ~write_q;
                if ((write_q && s_bready) || (!write_q && s_rready)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        pwrite = psel & write_q;
    end

    assign paddr   = addr_q;
    assign pprot   = prot_q;
    assign pwdata  = wdata_q;
    assign pstrb   = strb_q;
    assign s_bresp = resp_q;
    assign s_rresp = resp_q;
    assign s_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_prio_q <= 1'b1;
            write_q   <= 1'b0;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_prio_q <= rd_prio_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Self-checking bench for axil_apb_bridge: directed vector table, random transfers against a
// behavioural model, and hand-written arbitration / backpressure / reset sequences.
module tb_axil_apb_bridge;
    localparam int TO = 8;

    logic        clk, rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, paddr, pwdata, prdata;
    logic [2:0]  s_awprot, s_arprot, pprot;
    logic [3:0]  s_wstrb, pstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        psel, penable, pwrite, pready, pslverr;

    axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          acc_len;
        logic        err;
        logic        never;
        logic [31:0] prdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_acc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs and bus monitor state
    int          cfg_acc_len = 1;
    logic        cfg_err = 1'b0, cfg_never = 1'b0;
    logic [31:0] cfg_prdata = '0;
    int          mon_setup = 0, mon_acc = 0, mon_done = 0, mon_unstable = 0;
    logic [31:0] mon_addr = '0, mon_wdata = '0;
    logic [3:0]  mon_strb = '0;
    logic [2:0]  mon_prot = '0;
    logic        mon_write = 1'b0;

    logic        exp_rd_prio = 1'b1;
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // APB slave: noisy pready/pslverr in SETUP and idle, pready on the cfg_acc_len-th ACCESS cycle
    initial begin
        int n;
        n = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(posedge clk); #1;
            if (psel && penable) n++; else n = 0;
            if (psel && !penable) begin
                pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
            end else if (psel && penable && !cfg_never && n >= cfg_acc_len) begin
                pready = 1'b1; pslverr = cfg_err; prdata = cfg_prdata;
            end else begin
                pready  = !psel && ($urandom_range(0, 1) == 1);
                pslverr = ($urandom_range(0, 1) == 1);
                prdata  = $urandom();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && psel && !penable) begin
                mon_setup++;
                mon_addr = paddr; mon_wdata = pwdata; mon_strb = pstrb;
                mon_prot = pprot; mon_write = pwrite;
            end else if (!rst && psel && penable) begin
                mon_acc++;
                if (paddr !== mon_addr || pwdata !== mon_wdata || pstrb !== mon_strb ||
                    pprot !== mon_prot || pwrite !== mon_write) mon_unstable++;
                if (pready) mon_done++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_acc   = v.never ? TO : v.acc_len;
        r.exp_resp  = (v.never || v.err) ? 2'b10 : 2'b00;
        r.exp_rdata = (v.wr || v.never) ? 32'h0 : v.prdata;
        return r;
    endfunction

    // Entered and left at posedge+1 with the bridge idle.
    task automatic run_vec(input vec_t v, input string tag, input int hold);
        int acc0, set0, done0, uns0, lat;
        logic got, seen;
        logic [1:0]  resp;
        logic [31:0] rdata;
        acc0 = mon_acc; set0 = mon_setup; done0 = mon_done; uns0 = mon_unstable;
        cfg_acc_len = v.acc_len; cfg_err = v.err; cfg_never = v.never; cfg_prdata = v.prdata;
        if (v.wr) begin
            s_awvalid = 1'b1; s_awaddr = v.addr; s_awprot = v.prot;
            s_wvalid = 1'b1; s_wdata = v.wdata; s_wstrb = v.strb;
        end else begin
            s_arvalid = 1'b1; s_araddr = v.addr; s_arprot = v.prot;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = v.wr ? (s_awready && s_wready) : s_arready;
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check({tag, ".accepted"}, got, 1);
        if (got) exp_rd_prio = !exp_rd_prio;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < TO + 12 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = v.wr ? s_bvalid : s_rvalid;
        end
        check({tag, ".responded"}, seen, 1);
        check({tag, ".other_valid"}, v.wr ? s_rvalid : s_bvalid, 0);
        resp  = v.wr ? s_bresp : s_rresp;
        rdata = s_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (v.wr) s_arvalid = 1'b1; else begin s_awvalid = 1'b1; s_wvalid = 1'b1; end
            @(negedge clk);
            check({tag, ".hold_valid"}, v.wr ? s_bvalid : s_rvalid, 1);
            check({tag, ".hold_resp"}, v.wr ? s_bresp : s_rresp, resp);
            check({tag, ".hold_no_accept"}, {s_arready, s_awready, s_wready, psel}, 0);
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = v.wr; s_rready = !v.wr;
        @(posedge clk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        check({tag, ".resp"}, resp, v.exp_resp);
        if (!v.wr) check({tag, ".rdata"}, rdata, v.exp_rdata);
        else if (!v.never) check({tag, ".rdata_kept"}, rdata, last_rdata);
        if (!v.wr) last_rdata = v.exp_rdata;
        check({tag, ".latency"}, lat, v.exp_acc + 2);
        check({tag, ".setup_cycles"}, mon_setup - set0, 1);
        check({tag, ".access_cycles"}, mon_acc - acc0, v.exp_acc);
        check({tag, ".completed"}, mon_done - done0, v.never ? 0 : 1);
        check({tag, ".stable"}, mon_unstable - uns0, 0);
        check({tag, ".paddr"}, mon_addr, v.addr);
        check({tag, ".pwrite"}, mon_write, v.wr);
        check({tag, ".pprot"}, mon_prot, v.prot);
        check({tag, ".pwdata"}, mon_wdata, v.wr ? v.wdata : 32'h0);
        check({tag, ".pstrb"}, mon_strb, v.wr ? v.strb : 4'h0);
        check({tag, ".idle_after"}, {s_bvalid, s_rvalid, psel}, 0);
    endtask

    vec_t vecs[8];
    vec_t v;
    logic got, gr, gw;
    int   ng;

    initial begin
        vecs[0] = '{1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 3'd0, 1, 1'b0, 1'b0, 32'h5555_AAAA,
                    2'b00, 32'h0, 1};
        vecs[1] = '{1'b0, 32'h2004, 32'h0, 4'h0, 3'd2, 3, 1'b0, 1'b0, 32'h1234_5678,
                    2'b00, 32'h1234_5678, 3};
        vecs[2] = '{1'b0, 32'h2008, 32'h0, 4'h0, 3'd1, 2, 1'b1, 1'b0, 32'hCAFE_F00D,
                    2'b10, 32'hCAFE_F00D, 2};
        vecs[3] = '{1'b0, 32'h200C, 32'h0, 4'h0, 3'd0, 1, 1'b0, 1'b0, 32'h0BAD_F00D,
                    2'b00, 32'h0BAD_F00D, 1};
        vecs[4] = '{1'b1, 32'h3000, 32'h1122_3344, 4'h5, 3'd7, 1, 1'b1, 1'b0, 32'h9999_9999,
                    2'b10, 32'h0, 1};
        vecs[5] = '{1'b1, 32'h3004, 32'hA5A5_A5A5, 4'h3, 3'd0, 1, 1'b0, 1'b1, 32'h0,
                    2'b10, 32'h0, TO};
        vecs[6] = '{1'b0, 32'h3008, 32'h0, 4'h0, 3'd0, 1, 1'b0, 1'b1, 32'h7777_7777,
                    2'b10, 32'h0, TO};
        vecs[7] = '{1'b0, 32'h300C, 32'h0, 4'h0, 3'd4, TO, 1'b0, 1'b0, 32'h89AB_CDEF,
                    2'b00, 32'h89AB_CDEF, TO};

        rst = 1'b1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0; s_arprot = '0;
        repeat (3) @(negedge clk);
        check("reset.apb_ctrl", {psel, penable, pwrite}, 0);
        check("reset.valids", {s_bvalid, s_rvalid}, 0);
        check("reset.readies", {s_arready, s_awready, s_wready}, 0);
        check("reset.regs", {s_rdata, s_bresp, s_rresp, pstrb}, 0);
        check("reset.paddr_pwdata", {paddr, pwdata}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Half of a write request must never be accepted on its own
        s_awvalid = 1'b1; s_awaddr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only.no_accept", {s_awready, s_wready, psel}, 0);
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b1; s_wdata = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w_only.no_accept", {s_awready, s_wready, psel}, 0);
            @(posedge clk); #1;
        end
        s_wvalid = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

        v = '{1'b1, 32'h4000, 32'h0F0F_0F0F, 4'h8, 3'd0, 2, 1'b0, 1'b0, 32'h0,
              2'b00, 32'h0, 2};
        run_vec(v, "bready_hold", 5);

        for (int i = 0; i < 40; i++) begin
            v.wr      = ($urandom_range(0, 1) == 1);
            v.addr    = $urandom() & 32'hFFFF_FFFC;
            v.wdata   = $urandom();
            v.strb    = 4'($urandom_range(0, 15));
            v.prot    = 3'($urandom_range(0, 7));
            v.acc_len = int'($urandom_range(1, TO));
            v.err     = ($urandom_range(0, 3) == 0);
            v.never   = ($urandom_range(0, 7) == 0);
            v.prdata  = $urandom();
            run_vec(model(v), $sformatf("rand%0d", i), 0);
        end

        // Reset while in ACCESS drops the read without a response
        cfg_never = 1'b1;
        s_arvalid = 1'b1; s_araddr = 32'h5000; s_arprot = 3'd0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = s_arready;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        check("midrst.accepted", got, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst.in_access", {psel, penable}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("midrst.apb_dropped", {psel, penable, pwrite}, 0);
        check("midrst.no_resp", {s_rvalid, s_bvalid}, 0);
        @(negedge clk);
        rst = 1'b0;
        cfg_never = 1'b0;
        exp_rd_prio = 1'b1;
        last_rdata = '0;
        check("midrst.rdata_cleared", s_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst.still_quiet", {s_rvalid, s_bvalid, psel}, 0);
        end
        @(posedge clk); #1;

        // Both requests held: grants alternate, read first after reset
        cfg_acc_len = 1; cfg_err = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'h6000;
        s_awvalid = 1'b1; s_awaddr = 32'h7000; s_wvalid = 1'b1; s_wdata = 32'h0; s_wstrb = 4'hF;
        s_bready = 1'b1; s_rready = 1'b1;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            gr = s_arready;
            gw = s_awready && s_wready;
            if (gr || gw) begin
                check($sformatf("arb.grant%0d_read", ng), gr, exp_rd_prio);
                check($sformatf("arb.grant%0d_write", ng), gw, !exp_rd_prio);
                exp_rd_prio = !exp_rd_prio;
                ng++;
            end
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("arb.grant_count", ng, 4);
        repeat (6) @(posedge clk);
        #1;
        s_bready = 1'b0; s_rready = 1'b0;
        @(negedge clk);
        check("arb.drained", {s_bvalid, s_rvalid, psel}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_apb_bridge.md
Name: axil_apb_bridge

Overview:
Single-outstanding bridge converting AXI4-Lite slave transactions into APB4 master transfers. Sits directly upstream of the ApbIO master modport and drives the peripheral APB segment (timers, UART, PLIC-style slaves). The bridge serialises reads and writes, arbitrates fairly between them, and converts APB errors and timeouts into AXI SLVERR responses.

Parameters:
ADDR_WIDTH, `PADDR_SIZE, width of AXI address and paddr
DATA_WIDTH, `XLEN, width of data buses; strobe width is DATA_WIDTH/8
TIMEOUT, 255, ACCESS-phase cycle limit before forced error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_awvalid/s_awready  in/out  1  AXI write address handshake
s_awaddr  in  ADDR_WIDTH  write address
s_awprot  in  3  write protection
s_wvalid/s_wready  in/out  1  AXI write data handshake
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  write strobes
s_bvalid/s_bready  out/in  1  write response handshake
s_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s_arvalid/s_arready  in/out  1  read address handshake
s_araddr  in  ADDR_WIDTH  read address
s_arprot  in  3  read protection
s_rvalid/s_rready  out/in  1  read data handshake
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
paddr  out  ADDR_WIDTH  APB address
pprot  out  3  APB protection
psel/penable/pwrite  out  1  APB control
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Clocking: one clock (clk); reset rst is asynchronous and active-high. On reset, all valid/ready outputs, psel, penable and pwrite are 0; state is IDLE; data, address, strobe and response registers are 0; the priority bit selects read.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE, request eligibility: a read is eligible when s_arvalid=1. A write is eligible only when s_awvalid=1 and s_wvalid=1 in the same cycle.
- IDLE, arbitration: if both are eligible, the priority bit picks the winner, and the priority bit toggles after every granted transfer (round-robin).
- IDLE, acceptance: ready outputs are combinational, asserted only in IDLE and only for the winner. s_awready and s_wready are asserted together.
- IDLE, capture: addr, prot, wdata and wstrb are registered on the handshake. For reads, pstrb=0 and pwdata=0.
- SETUP (1 cycle): psel=1, penable=0, APB fields driven from registers; next state is ACCESS.
- ACCESS: psel=1, penable=1, fields stable. On pready=1: capture prdata (reads) and set the response to SLVERR if pslverr=1, else OKAY; go to RESP.
- ACCESS timeout: a counter clears on SETUP entry and increments each ACCESS cycle. If TIMEOUT!=0 and the count reaches TIMEOUT with pready=0, drop psel/penable, set response to SLVERR with rdata=0, and go to RESP.
- RESP: psel=0, penable=0. Assert s_bvalid (write) or s_rvalid (read) with the registered resp/data, held stable until s_bready or s_rready; then return to IDLE.
- Back-to-back throughput: minimum 4 cycles per transfer (accept, SETUP, ACCESS, RESP); no pipelining and exactly one outstanding transfer.
- Reset mid-transfer: returns to IDLE immediately with psel=0; the in-flight AXI transaction is dropped with no response.
- Corner cases:
  - s_awvalid without s_wvalid (or the reverse) is never accepted alone.
  - prdata is ignored on writes.
  - pready sampled in SETUP is ignored.

Test Plan:
- Write 0x1000 data 0xDEADBEEF strb 0xF, pready=1 in first ACCESS -> one SETUP cycle then one ACCESS cycle with pwrite=1, pstrb=0xF; s_bvalid with bresp=00 in the cycle after ACCESS.
- Read 0x2004, pready delayed 3 ACCESS cycles, prdata=0x12345678 -> penable held 3 cycles with paddr stable; rdata=0x12345678, rresp=00.
- Read with pslverr=1 at pready -> rresp=2'b10; next read with pslverr=0 returns 00.
- TIMEOUT=8, pready never asserted -> psel drops after 8 ACCESS cycles; bresp=10 for a write, or rdata=0 and rresp=10 for a read.
- Read and write valid simultaneously, both held continuously -> grants alternate R,W,R,W, starting with read after reset.
- Hold s_bready=0 for 5 cycles -> s_bvalid and bresp stable, no new acceptance; assert rst during ACCESS -> psel=0 asynchronously, FSM in IDLE.
